// File: rtl/arith_loop_gen.sv
// -----------------------------------------------------------------------------
// arith_loop_gen
//
// Accumulation loop: on every accepted step, accumulator x is updated from
// counter y under a selectable arithmetic mode, then y advances by STEP and is
// clamped at LIMIT. Once y reaches LIMIT the block parks in DONE until rst or
// restart. Also tracks a sticky overflow/underflow flag and a step counter.
//
// Ports:
//   clk       in   1      clock, all state updates on the rising edge
//   rst       in   1      synchronous active-high reset
//   selector  in   1      step enable, sampled each cycle
//   restart   in   1      synchronous reload of initial values (below rst)
//   mode      in   2      00 wrap add, 01 saturating add, 10 wrap sub, 11 idle
//   x         out  WIDTH  accumulator
//   y         out  WIDTH  loop counter, never exceeds LIMIT
//   steps     out  WIDTH  accepted steps since reset/restart, wraps
//   ovf       out  1      sticky overflow/underflow flag
//   done      out  1      high while y == LIMIT
// -----------------------------------------------------------------------------
module arith_loop_gen #(
  parameter int WIDTH  = 15,
  parameter int LIMIT  = 250,
  parameter int STEP   = 1,
  parameter int X_INIT = 1,
  parameter int Y_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  input  logic             restart,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] steps,
  output logic             ovf,
  output logic             done
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_WADD = 2'b00,
    MODE_SADD = 2'b01,
    MODE_WSUB = 2'b10,
    MODE_IDLE = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] X_RST   = WIDTH'(X_INIT);
  localparam logic [WIDTH-1:0] Y_RST   = WIDTH'(Y_INIT);
  localparam logic [WIDTH:0]   LIMIT_E = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0]   STEP_E  = (WIDTH+1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             ovf_q, ovf_d;

  logic             step_en;
  mode_e            mode_s;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   y_sum;
  logic             y_hits_limit;

  assign mode_s = mode_e'(mode);

  // Shared arithmetic; both computed one bit wider so the carry is visible.
  assign sum          = {1'b0, x_q} + {1'b0, y_q};
  assign y_sum        = {1'b0, y_q} + STEP_E;
  assign y_hits_limit = (y_sum >= LIMIT_E);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (restart)                     state_d = ST_RUN;
    else if (step_en && y_hits_limit) state_d = ST_DONE;
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // done follows the state register, which flips to DONE on the same edge that
  // writes LIMIT into y, so done == (y == LIMIT) by construction.
  always_comb begin
    step_en = (state_q == ST_RUN) && selector && (mode_s != MODE_IDLE);
    done    = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    steps_d = steps_q;
    ovf_d   = ovf_q;

    if (restart) begin
      x_d     = X_RST;
      y_d     = Y_RST;
      steps_d = '0;
      ovf_d   = 1'b0;
    end else if (step_en) begin
      unique case (mode_s)
        MODE_WADD: begin
          x_d   = sum[WIDTH-1:0];
          ovf_d = ovf_q | sum[WIDTH];
        end
        MODE_SADD: begin
          x_d   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
          ovf_d = ovf_q | sum[WIDTH];
        end
        MODE_WSUB: begin
          x_d   = x_q - y_q;
          ovf_d = ovf_q | (x_q < y_q);
        end
        default: begin
          // MODE_IDLE never reaches here because step_en excludes it.
          x_d   = x_q;
          ovf_d = ovf_q;
        end
      endcase
      y_d     = y_hits_limit ? LIMIT_E[WIDTH-1:0] : y_sum[WIDTH-1:0];
      steps_d = steps_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= X_RST;
      y_q     <= Y_RST;
      steps_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      steps_q <= steps_d;
      ovf_q   <= ovf_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign steps = steps_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_arith_loop_gen.sv
// -----------------------------------------------------------------------------
// tb_arith_loop_gen
//
// Directed bench for arith_loop_gen. Three instances share one set of inputs:
//   u_dut_a : defaults (WIDTH 15, LIMIT 250, STEP 1)
//   u_dut_b : WIDTH 8, LIMIT 100 (overflow / saturation cases)
//   u_dut_c : STEP 7, LIMIT 20   (clamping of y)
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_arith_loop_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       selector;
  logic       restart;
  logic [1:0] mode;

  logic [14:0] a_x, a_y, a_steps;
  logic        a_ovf, a_done;
  logic [7:0]  b_x, b_y, b_steps;
  logic        b_ovf, b_done;
  logic [14:0] c_x, c_y, c_steps;
  logic        c_ovf, c_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  arith_loop_gen u_dut_a (
    .clk(clk), .rst(rst), .selector(selector), .restart(restart), .mode(mode),
    .x(a_x), .y(a_y), .steps(a_steps), .ovf(a_ovf), .done(a_done)
  );

  arith_loop_gen #(.WIDTH(8), .LIMIT(100)) u_dut_b (
    .clk(clk), .rst(rst), .selector(selector), .restart(restart), .mode(mode),
    .x(b_x), .y(b_y), .steps(b_steps), .ovf(b_ovf), .done(b_done)
  );

  arith_loop_gen #(.STEP(7), .LIMIT(20)) u_dut_c (
    .clk(clk), .rst(rst), .selector(selector), .restart(restart), .mode(mode),
    .x(c_x), .y(c_y), .steps(c_steps), .ovf(c_ovf), .done(c_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; selector = 1'b0; mode = 2'b00;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; selector = 1'b0; mode = 2'b00;

    // Reset state
    do_reset();
    check("rst_x",     a_x,     1);
    check("rst_y",     a_y,     0);
    check("rst_steps", a_steps, 0);
    check("rst_ovf",   a_ovf,   0);
    check("rst_done",  a_done,  0);

    // Wrap add on all three instances, selector held high
    mode = 2'b00; selector = 1'b1;
    cyc(2);                                   // 2 steps
    check("c_y_2",    c_y,    14);
    check("c_x_2",    c_x,    8);
    check("c_done_2", c_done, 0);
    cyc(1);                                   // 3 steps: y clamps 21 -> 20
    check("c_y_3",    c_y,    20);
    check("c_x_3",    c_x,    22);
    check("c_done_3", c_done, 1);
    cyc(20);                                  // 23 steps
    check("b_x_23",   b_x,    254);
    check("b_y_23",   b_y,    23);
    check("b_ovf_23", b_ovf,  0);
    cyc(1);                                   // 24 steps: 254+23 wraps to 21
    check("b_x_24",   b_x,    21);
    check("b_y_24",   b_y,    24);
    check("b_ovf_24", b_ovf,  1);
    cyc(6);                                   // 30 steps
    check("b_ovf_30",   b_ovf,   1);
    check("c_hold_x",   c_x,     22);
    check("c_hold_y",   c_y,     20);
    check("c_hold_st",  c_steps, 3);
    cyc(219);                                 // 249 steps
    check("a_y_249",    a_y,    249);
    check("a_done_249", a_done, 0);
    cyc(1);                                   // 250 steps
    check("a_y_250",     a_y,     250);
    check("a_x_250",     a_x,     31126);
    check("a_steps_250", a_steps, 250);
    check("a_done_250",  a_done,  1);
    check("a_ovf_250",   a_ovf,   0);
    cyc(10);                                  // DONE holds everything
    check("a_hold_x",     a_x,     31126);
    check("a_hold_y",     a_y,     250);
    check("a_hold_steps", a_steps, 250);
    check("a_hold_done",  a_done,  1);

    // Saturating add on the 8-bit instance
    do_reset();
    mode = 2'b01; selector = 1'b1;
    cyc(23);
    check("sat_x_23", b_x, 254);
    cyc(1);
    check("sat_x_24",   b_x,   255);
    check("sat_ovf_24", b_ovf, 1);
    check("sat_y_24",   b_y,   24);
    cyc(2);
    check("sat_x_26",   b_x,     255);
    check("sat_y_26",   b_y,     26);
    check("sat_st_26",  b_steps, 26);

    // Wrap subtract on the default instance
    do_reset();
    mode = 2'b10; selector = 1'b1;
    cyc(1);
    check("sub_x_1",   a_x,   1);
    check("sub_y_1",   a_y,   1);
    check("sub_ovf_1", a_ovf, 0);
    cyc(1);
    check("sub_x_2",   a_x,   0);
    check("sub_y_2",   a_y,   2);
    check("sub_ovf_2", a_ovf, 0);
    cyc(1);
    check("sub_x_3",   a_x,   32766);
    check("sub_y_3",   a_y,   3);
    check("sub_ovf_3", a_ovf, 1);
    cyc(1);                                   // 32766 - 3, no new borrow
    check("sub_x_4",   a_x,   32763);
    check("sub_ovf_4", a_ovf, 1);

    // Restart mid-run, overriding a simultaneous selector
    do_reset();
    mode = 2'b00; selector = 1'b1;
    cyc(40);
    check("mid_y_40", a_y, 40);
    check("mid_x_40", a_x, 781);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("rs_x",     a_x,     1);
    check("rs_y",     a_y,     0);
    check("rs_steps", a_steps, 0);
    check("rs_ovf",   a_ovf,   0);
    check("rs_done",  a_done,  0);
    check("rs_c_done", c_done, 0);

    // No step with selector low, nor with mode 11
    selector = 1'b0;
    cyc(5);
    check("idle_sel_x", a_x,     1);
    check("idle_sel_y", a_y,     0);
    check("idle_sel_s", a_steps, 0);
    selector = 1'b1; mode = 2'b11;
    cyc(5);
    check("idle_m3_x", a_x,     1);
    check("idle_m3_y", a_y,     0);
    check("idle_m3_s", a_steps, 0);
    mode = 2'b00;
    cyc(3);
    check("resume_x", a_x,     4);
    check("resume_y", a_y,     3);
    check("resume_s", a_steps, 3);
    check("resume_c_done", c_done, 1);

    // Restart leaves DONE
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("rsd_c_done", c_done, 0);
    check("rsd_c_y",    c_y,    0);
    check("rsd_c_x",    c_x,    1);

    // rst together with restart gives reset values
    mode = 2'b10;
    cyc(3);                                   // drives ovf high on a
    check("pre_rst_ovf", a_ovf, 1);
    rst = 1'b1; restart = 1'b1; mode = 2'b00;
    cyc(1);
    rst = 1'b0; restart = 1'b0; selector = 1'b0;
    check("rr_x",     a_x,     1);
    check("rr_y",     a_y,     0);
    check("rr_steps", a_steps, 0);
    check("rr_ovf",   a_ovf,   0);
    check("rr_done",  a_done,  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
